// File: rtl/entropy_pkg.sv
// Shared types and defaults for the entropy source scheduler and its arbiter helpers.
package entropy_pkg;

  localparam int NUM_SRC_DEF     = 3;
  localparam int WORD_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int RCT_LIMIT_DEF   = 16;
  localparam int SRC_IDX_W       = $clog2(NUM_SRC_DEF);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_PRESENT = 2'd2;

  // Index width that stays legal for a single-entry arbiter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Combinational round-robin search: first eligible index strictly after ptr_i,
// wrapping, so ptr_i itself is the last candidate.
module rr_next_picker
  import entropy_pkg::*;
#(
  parameter int N  = NUM_SRC_DEF,
  parameter int IW = SRC_IDX_W
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand_s;

  // Scan offsets 1..N from the pointer and keep the first hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand_s  = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = IW'((int'(ptr_i) + k) % N);
      if (!found_o && eligible_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/entropy_source_scheduler.sv
// Shares one bit-collection datapath across NUM_SRC entropy sources with
// round-robin selection, stall timeout and repetition-count health testing.
module entropy_source_scheduler
  import entropy_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int RCT_LIMIT   = RCT_LIMIT_DEF,
  localparam int IW         = idx_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [NUM_SRC-1:0] src_bit,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic               health_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [IW-1:0]      out_src,
  output logic               timeout_pulse,
  output logic [NUM_SRC-1:0] health_fail,
  output logic               busy
);

  localparam int CW = $clog2(WORD_W);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WORD_W - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    RCT_HIT    = 8'(RCT_LIMIT);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [7:0]         run_q, run_d;
  logic               prev_q, prev_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_word_q, out_word_d;
  logic [IW-1:0]      out_src_q, out_src_d;
  logic               timeout_q, timeout_d;
  logic [NUM_SRC-1:0] health_q, health_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] fail_set_s;
  logic               found_s;
  logic [IW-1:0]      pick_s;
  logic               vld_s, bit_s, en_s;
  logic [WORD_W-1:0]  shift_s;
  logic [7:0]         run_next_s;

  assign eligible_s = src_enable & ~health_q;
  assign vld_s      = src_valid[ptr_q];
  assign bit_s      = src_bit[ptr_q];
  assign en_s       = src_enable[ptr_q];
  assign shift_s    = {word_q[WORD_W-2:0], bit_s};
  assign run_next_s = ((bitcnt_q == '0) || (bit_s != prev_q)) ? 8'd1 : (run_q + 8'd1);

  rr_next_picker #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_picker (
    .eligible_i (eligible_s),
    .ptr_i      (ptr_q),
    .found_o    (found_s),
    .idx_o      (pick_s)
  );

  // Next-state logic; within COLLECT a captured bit outranks timeout and disable.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    word_d      = word_q;
    bitcnt_d    = bitcnt_q;
    stall_d     = stall_q;
    run_d       = run_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_src_d   = out_src_q;
    timeout_d   = 1'b0;
    fail_set_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d  = ST_COLLECT;
          ptr_d    = pick_s;
          word_d   = '0;
          bitcnt_d = '0;
          stall_d  = '0;
          run_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (vld_s) begin
          word_d   = shift_s;
          bitcnt_d = bitcnt_q + 1'b1;
          stall_d  = '0;
          run_d    = run_next_s;
          prev_d   = bit_s;
          // A bit that both completes the word and hits the limit is discarded.
          if (run_next_s == RCT_HIT) begin
            fail_set_s[ptr_q] = 1'b1;
            state_d           = ST_IDLE;
          end else if (bitcnt_q == LAST_BIT) begin
            out_valid_d = 1'b1;
            out_word_d  = shift_s;
            out_src_d   = ptr_q;
            state_d     = ST_PRESENT;
          end else if (!en_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          stall_d = stall_q + 1'b1;
          if (stall_q == STALL_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (!en_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_PRESENT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // A failure raised this cycle survives a simultaneous clear.
    if (health_clear) begin
      health_d = fail_set_s;
    end else begin
      health_d = health_q | fail_set_s;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IW'(NUM_SRC - 1);
      word_q      <= '0;
      bitcnt_q    <= '0;
      stall_q     <= '0;
      run_q       <= '0;
      prev_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_src_q   <= '0;
      timeout_q   <= 1'b0;
      health_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      word_q      <= word_d;
      bitcnt_q    <= bitcnt_d;
      stall_q     <= stall_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_src_q   <= out_src_d;
      timeout_q   <= timeout_d;
      health_q    <= health_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_word      = out_word_q;
  assign out_src       = out_src_q;
  assign timeout_pulse = timeout_q;
  assign health_fail   = health_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_entropy_source_scheduler.sv
// Scoreboard bench: stimulus pushes expected {src, word}; a monitor pops on each handshake.
module tb_entropy_source_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src_valid, src_bit, src_enable;
  logic       health_clear, out_valid, out_ready, timeout_pulse, busy;
  logic [7:0] out_word;
  logic [1:0] out_src;
  logic [2:0] health_fail;

  typedef struct packed {logic [1:0] src; logic [7:0] word;} exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vec = 0, n_err = 0;
  int   edge_cnt = 0, anchor = 1000000, tmo_cnt = 0, tmo_edge = -1;
  logic rct_mode = 1'b0;
  logic [7:0] pat8 [3];

  entropy_source_scheduler #(.RCT_LIMIT(6)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_bit(src_bit),
    .src_enable(src_enable), .health_clear(health_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_src(out_src),
    .timeout_pulse(timeout_pulse), .health_fail(health_fail), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream bit for edge n: 10-cycle slots from anchor, bits at phases 0..7, MSB of word first.
  function automatic logic stream_bit(input int i, input int n);
    int p, slot, ph;
    logic [15:0] rp;
    p = n - anchor;
    if (p < 0) return 1'b0;
    slot = p / 10;
    ph   = p % 10;
    if (ph >= 8) return 1'b0;
    if (rct_mode && i == 1) begin
      rp = 16'hFDE5;
      return rp[(slot * 8 + ph) % 16];
    end
    return pat8[i][7 - ph];
  endfunction

  initial begin
    src_bit = 3'b000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) src_bit[i] = stream_bit(i, edge_cnt + 1);
    end
  end

  // Monitor: sampled after the negedge drive, reflecting what the next posedge sees.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      acc_q.push_back(edge_cnt);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got src %0d word 0x%02h, none expected", out_src, out_word);
      end else begin
        e = exp_q.pop_front();
        check("out_src", 32'(out_src), 32'(e.src));
        check("out_word", 32'(out_word), 32'(e.word));
      end
    end
    if (!rst && timeout_pulse) begin
      tmo_cnt++;
      tmo_edge = edge_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [1:0] s, input logic [7:0] w);
    exp_t e;
    e.src  = s;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_word"}, 32'(out_word), 32'd0);
    check({tag, "_out_src"}, 32'(out_src), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_pulse), 32'd0);
    check({tag, "_health"}, 32'(health_fail), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src_enable = 3'b000;
    src_valid = 3'b000;
    health_clear = 1'b0;
    out_ready = 1'b1;
    rct_mode = 1'b0;
    #1;
    check_zero_outputs("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
  endtask

  task automatic wait_drain(input int limit);
    int c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, g, r, c;
    rst = 1'b1;
    src_valid = 3'b000; src_enable = 3'b000; health_clear = 1'b0; out_ready = 1'b0;
    pat8[0] = 8'h55; pat8[1] = 8'hC3; pat8[2] = 8'h96;
    repeat (2) @(negedge clk);
    check_zero_outputs("init");

    // T1: single source, alternating bits, back-to-back words every 10 cycles.
    do_reset();
    n = edge_cnt + 1;
    anchor = n + 1;
    src_enable = 3'b001; src_valid = 3'b001;
    repeat (3) push(2'd0, 8'h55);
    wait_drain(100);
    check("t1_first_lat", 32'(acc_q[0]), 32'(n + 8));
    check("t1_period_a", 32'(acc_q[1]), 32'(n + 18));
    check("t1_period_b", 32'(acc_q[2]), 32'(n + 28));

    // T2: all sources eligible, rotation 0,1,2,0,1,2.
    do_reset();
    n = edge_cnt + 1;
    anchor = n + 1;
    src_enable = 3'b111; src_valid = 3'b111;
    repeat (2) begin
      push(2'd0, 8'h55); push(2'd1, 8'hC3); push(2'd2, 8'h96);
    end
    wait_drain(150);
    check("t2_last_edge", 32'(acc_q[5]), 32'(n + 58));

    // T3: repetition count failure on source 1, then re-admission by health_clear.
    do_reset();
    n = edge_cnt + 1;
    anchor = n + 1;
    rct_mode = 1'b1;
    src_enable = 3'b010; src_valid = 3'b010;
    push(2'd1, 8'hA7);
    while (edge_cnt < n + 18) @(negedge clk);
    check("t3_fail_flag", 32'(health_fail), 32'h2);
    check("t3_idle", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    check("t3_word_count", 32'(acc_q.size()), 32'd1);
    health_clear = 1'b1;
    g = edge_cnt + 1;
    anchor = g + 2;
    push(2'd1, 8'hA7);
    @(negedge clk);
    health_clear = 1'b0;
    check("t3_cleared", 32'(health_fail), 32'h0);
    while (edge_cnt < g + 19) @(negedge clk);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_refail", 32'(health_fail), 32'h2);

    // T4: stalled source 2 times out after 64 cycles, scheduler moves to source 0.
    do_reset();
    n = edge_cnt + 1;
    anchor = n + 66;
    src_enable = 3'b100; src_valid = 3'b001;
    tmo_cnt = 0;
    push(2'd0, 8'h55);
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd1);
    src_enable = 3'b101;
    wait_drain(150);
    check("t4_tmo_count", 32'(tmo_cnt), 32'd1);
    check("t4_tmo_edge", 32'(tmo_edge - n), 32'd64);
    check("t4_health", 32'(health_fail), 32'h0);
    check("t4_word_edge", 32'(acc_q[0]), 32'(n + 73));

    // T5: back-pressure for 20 cycles holds the presented word.
    do_reset();
    n = edge_cnt + 1;
    anchor = n + 1;
    pat8[0] = 8'h3C;
    src_enable = 3'b001; src_valid = 3'b001; out_ready = 1'b0;
    push(2'd0, 8'h3C);
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t5_valid_edge", 32'(edge_cnt), 32'(n + 8));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_word", 32'(out_word), 32'h3C);
      check("t5_hold_src", 32'(out_src), 32'd0);
    end
    out_ready = 1'b1;
    r = edge_cnt + 1;
    anchor = r + 2;
    pat8[0] = 8'hE7;
    wait_drain(10);
    check("t5_accept_edge", 32'(acc_q[0]), 32'(r - 1));

    // T6: reset after 5 bits of the next word loses everything.
    while (edge_cnt < r + 6) @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6");
    repeat (2) @(negedge clk);
    pat8[0] = 8'h55;
    rst = 1'b0;
    acc_q.delete();
    n = edge_cnt + 1;
    anchor = n + 1;
    push(2'd0, 8'h55);
    wait_drain(40);
    check("t6_first_edge", 32'(acc_q[0]), 32'(n + 8));

    @(negedge clk);
    src_enable = 3'b000;
    repeat (12) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
